// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared size/state encodings and alignment helper for the memory access unit.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD1  = 3'd1,
        S_RD2  = 3'd2,
        S_RD3  = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5
    } state_e;

    localparam int READ_LAT = 2;

    // Read data is captured READ_LAT states after the address is first driven in RD1.
    localparam state_e S_CAPTURE = state_e'(3'(S_RD1) + 3'(READ_LAT));

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == SZ_RSVD) || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
    endfunction

endpackage

// File: rtl/mem_lane_sel.sv
// mem_lane_sel: little-endian lane extract with sign/zero extension and sub-word merge into a read word.
module mem_lane_sel
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] ext,
    output logic [31:0] merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] mask;
    logic [31:0] wrep;

    always_comb begin
        lane_b = word[{off, 3'b000} +: 8];
        lane_h = word[{off[1], 4'b0000} +: 16];
        ext    = (size == SZ_BYTE) ? {{24{sext & lane_b[7]}}, lane_b} :
                 (size == SZ_HALF) ? {{16{sext & lane_h[15]}}, lane_h} : word;
        // Replicate the store data across all lanes; the mask picks which ones land.
        mask   = (size == SZ_BYTE) ? (32'h0000_00FF << {off, 3'b000}) :
                 (size == SZ_HALF) ? (off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) : 32'hFFFF_FFFF;
        wrep   = (size == SZ_BYTE) ? {4{wdata[7:0]}} :
                 (size == SZ_HALF) ? {2{wdata[15:0]}} : wdata;
        merged = (word & ~mask) | (wrep & mask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer with aligned word access, sub-word read-modify-write
// and misalignment reporting.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic        sext_q, sext_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mem_wr_q, mem_wr_d;
    logic        err_q, err_d;
    logic [31:0] ext;
    logic [31:0] merged;

    mem_lane_sel u_lane (
        .size   (size_q),
        .sext   (sext_q),
        .off    (off_q),
        .word   (mem_rdata),
        .wdata  (wdata_q),
        .ext    (ext),
        .merged (merged)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        sext_d      = sext_q;
        size_d      = size_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        mem_wr_d    = 1'b0;
        case (state_q)
            S_IDLE: if (req) begin
                we_d    = we;
                sext_d  = sext;
                size_d  = size;
                off_d   = addr[1:0];
                wdata_d = wdata;
                if (misaligned(size, addr[1:0])) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    mem_addr_d = {addr[31:2], 2'b00};
                    if (we && size == SZ_WORD) begin
                        state_d     = S_WR;
                        mem_wr_d    = 1'b1;
                        mem_wdata_d = wdata;
                    end else begin
                        state_d = S_RD1;
                    end
                end
            end
            S_RD1, S_RD2: state_d = state_e'(state_q + 3'd1);
            S_CAPTURE: if (we_q) begin
                state_d     = S_WR;
                mem_wr_d    = 1'b1;
                mem_wdata_d = merged;
            end else begin
                state_d = S_DONE;
                rdata_d = ext;
                err_d   = 1'b0;
            end
            S_WR: begin
                state_d = S_DONE;
                err_d   = 1'b0;
            end
            S_DONE: begin
                state_d    = S_IDLE;
                mem_addr_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            sext_q      <= 1'b0;
            size_q      <= 2'b00;
            off_q       <= 2'b00;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            mem_wr_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            sext_q      <= sext_d;
            size_q      <= size_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            mem_wr_q    <= mem_wr_d;
            err_q       <= err_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL: clk  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL: rst  in  1  reset; one clock, reset is synchronous and active-high.
REQ-003 SHALL: req  in  1  start pulse; sampled only in IDLE.
REQ-004 SHALL: we  in  1  1 = store, 0 = load.
REQ-005 SHALL: size  in  2  0 word, 1 byte, 2 half; 3 reserved, treated as error.
REQ-006 SHALL: sext  in  1  load extension: 1 sign-extend, 0 zero-extend.
REQ-007 SHALL: addr  in  32  byte address.
REQ-008 SHALL: wdata  in  32  store data, right-justified.
REQ-009 SHALL: mem_addr  out  32  word address to memory, {addr[31:2],2'b00}.
REQ-010 SHALL: mem_wr  out  1  memory write strobe.
REQ-011 SHALL: mem_wdata  out  32  full word to memory.
REQ-012 SHALL: mem_rdata  in  32  memory read data, valid 2 cycles after mem_addr is first driven.
REQ-013 SHALL: rdata  out  32  extended load result.
REQ-014 SHALL: busy  out  1  high in every non-IDLE state.
REQ-015 SHALL: done  out  1  one-cycle completion pulse.
REQ-016 SHALL: err  out  1  misalignment/reserved flag, valid with done.

Function
REQ-017 SHALL: States are IDLE, RD1, RD2, RD3, WR, DONE.
REQ-018 SHALL: On req in IDLE (cycle T), latch we, size, sext, addr, wdata; later input changes are ignored until DONE.
REQ-019 SHALL: req while busy is ignored, with no queueing.
REQ-020 SHALL: Misalignment is size=2 with addr[0]=1, size=0 with addr[1:0]!=0, or size=3 -> IDLE->DONE; err=1, done at T+1, no memory access.
REQ-021 SHALL: Word store: IDLE->WR (T+1, mem_wr=1, mem_wdata=wdata) -> DONE (T+2).
REQ-022 SHALL: Load: IDLE->RD1->RD2->RD3; mem_rdata captured into a buffer at the end of RD3 (T+3); DONE at T+4.
REQ-023 SHALL: Sub-word store is read-modify-write: RD1..RD3 as for a load, then WR at T+4 with the merged word, then DONE at T+5.
REQ-024 SHALL: Lanes are little-endian; byte k = bits [8k+7:8k] with k=addr[1:0]; the half is selected by addr[1].
REQ-025 SHALL: Merge replaces only the addressed lane(s) with wdata[7:0] or wdata[15:0]; other lanes keep the buffered read value.
REQ-026 SHALL: Load result is the extracted lane, extended per sext to 32 bits; a word load passes through unchanged.
REQ-027 SHALL: rdata updates only at a load's DONE and holds until the next load completes; err holds its value from the last DONE.
REQ-028 SHALL: mem_wr is high only in WR and is registered, with no combinational path from req.
REQ-029 SHALL: mem_addr holds the latched word address from RD1/WR through DONE and is 0 in IDLE.
REQ-030 SHALL: done=1 only in DONE; DONE always returns to IDLE; a new req is accepted at the earliest the cycle after DONE.

Reset
REQ-031 SHALL: rst forces state IDLE and mem_wr, done, err, busy, rdata, mem_addr, mem_wdata, and all latches to 0 on the next edge.
REQ-032 SHALL: rst mid-operation aborts with no further mem_wr and no done pulse; if rst is asserted in WR, mem_wr is 0 from the next cycle.
REQ-033 SHALL: rst has priority over req in the same cycle.

Structure
REQ-034 SHALL: A shared package holds the size encodings (WORD=0, BYTE=1, HALF=2, matching controller adjsz/memow codes), the state encoding, and READ_LAT=2.
REQ-035 SHALL: Lane extract/merge logic lives in one combinational sub-module, mem_lane_sel; the FSM and registers live in mem_access_unit.

Verification (memory word at 0x10 = 0x88442211 unless stated)
REQ-036 SHALL: LB sext=1 addr=0x13 -> done at T+4, rdata=0xFFFFFF88, err=0, mem_wr never high.
REQ-037 SHALL: LH sext=0 addr=0x12 -> rdata=0x00008844 at T+4.
REQ-038 SHALL: SB addr=0x11 wdata=0x000000AB -> mem_wr only at T+4 with mem_wdata=0x8844AB11, mem_addr=0x10, done at T+5.
REQ-039 SHALL: SW addr=0x10 wdata=0xDEADBEEF -> mem_wr only at T+1 with mem_wdata=0xDEADBEEF, done at T+2.
REQ-040 SHALL: LH addr=0x11 -> done and err=1 at T+1, mem_wr=0 throughout; a second req at T+1 is ignored.
REQ-041 SHALL: SH addr=0x12 with rst at T+3 -> busy=0 from T+4, no mem_wr, no done; memory stays 0x88442211.
